// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program-counter and run-control stage sitting directly upstream of the ALU.
// Holds the PC that addresses instruction memory, latches the program start
// address used by the ALU for label resolution, redirects fetch on a taken
// branch and runs a small IDLE/RUN/DONE state machine that starts a program,
// counts its execution cycles and flags completion.
//
// Ports:
//   clk              system clock, all state updates on the rising edge
//   reset            synchronous, active-high reset
//   start_i          one-cycle request to begin execution at startAddr_i
//   startAddr_i      program entry address, sampled on an accepted start
//   branch_taken_i   ALU branch-taken flag for the instruction at pc_o
//   branch_target_i  ALU-computed branch target, used verbatim
//   halt_i           decoder flags the instruction at pc_o as program end
//   stall_i          hold the PC this cycle (multi-cycle memory op)
//   pc_o             current instruction address
//   startAddr_o      latched program start address (feeds the ALU)
//   running_o        high while in RUN
//   done_o           high while in DONE
//   cycle_count_o    cycles spent in RUN for the current program (saturating)
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [PC_W-1:0]  startAddr_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  branch_target_i,
  input  logic             halt_i,
  input  logic             stall_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  startAddr_o,
  output logic             running_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  start_addr_q, start_addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             running_q;
  logic             done_q;

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    start_addr_d = start_addr_q;
    count_d      = count_q;

    case (state_q)
      // DONE restarts exactly like IDLE; everything else there is frozen.
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d      = ST_RUN;
          pc_d         = startAddr_i;
          start_addr_d = startAddr_i;
          count_d      = '0;
        end
      end

      ST_RUN: begin
        // Counts every RUN edge, stall and halt cycles included; saturates.
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + CNT_W'(1);
        end

        // Priority: halt > stall > branch > sequential. A stall discards the
        // branch flag because the ALU re-presents it once the stall clears.
        if (halt_i) begin
          state_d = ST_DONE;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (branch_taken_i) begin
          pc_d = branch_target_i;
        end else begin
          pc_d = pc_q + PC_W'(1);  // wraps modulo 2^PC_W
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs. running/done are decoded from the next
  // state so they line up with the state register without a combinational
  // output decode.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      start_addr_q <= '0;
      count_q      <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      running_q    <= (state_d == ST_RUN);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign pc_o          = pc_q;
  assign startAddr_o   = start_addr_q;
  assign running_o     = running_q;
  assign done_o        = done_q;
  assign cycle_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Two instances share one input stream: a default one (CNT_W=16) and a
// narrow-counter one (CNT_W=4) to exercise saturation. A reference model
// tracks the program's abstract run status, PC and true (unbounded) cycle
// count; expected outputs are pushed into a queue by the stimulus process and
// a separate monitor pops and compares them after each rising edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam int PC_W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  start_addr_i;
  logic        branch_taken_i;
  logic [7:0]  branch_target_i;
  logic        halt_i;
  logic        stall_i;

  logic [7:0]  pc_o, start_addr_o;
  logic        running_o, done_o;
  logic [15:0] cycle_count_o;

  logic [7:0]  pc4_o, start_addr4_o;
  logic        running4_o, done4_o;
  logic [3:0]  cycle_count4_o;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.PC_W(PC_W), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .startAddr_i     (start_addr_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .halt_i          (halt_i),
    .stall_i         (stall_i),
    .pc_o            (pc_o),
    .startAddr_o     (start_addr_o),
    .running_o       (running_o),
    .done_o          (done_o),
    .cycle_count_o   (cycle_count_o)
  );

  pc_fetch_ctrl #(.PC_W(PC_W), .CNT_W(4)) dut4 (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .startAddr_i     (start_addr_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .halt_i          (halt_i),
    .stall_i         (stall_i),
    .pc_o            (pc4_o),
    .startAddr_o     (start_addr4_o),
    .running_o       (running4_o),
    .done_o          (done4_o),
    .cycle_count_o   (cycle_count4_o)
  );

  typedef struct {
    int pc;
    int sa;
    int run;
    int done;
    int cnt16;
    int cnt4;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: abstract program status plus true elapsed cycle count.
  bit m_running = 0;
  bit m_done    = 0;
  int m_pc      = 0;
  int m_sa      = 0;
  int m_cycles  = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // Apply one cycle of stimulus, advance the model and queue its prediction.
  task automatic cycle(input bit rst, input bit st, input int addr,
                       input bit br, input int tgt, input bit h, input bit s);
    exp_t e;
    @(negedge clk);
    reset           = rst;
    start_i         = st;
    start_addr_i    = addr[7:0];
    branch_taken_i  = br;
    branch_target_i = tgt[7:0];
    halt_i          = h;
    stall_i         = s;

    if (rst) begin
      m_running = 0; m_done = 0; m_pc = 0; m_sa = 0; m_cycles = 0;
    end else if (m_running) begin
      m_cycles++;
      if (h) begin
        m_running = 0;
        m_done    = 1;
      end else if (!s) begin
        m_pc = br ? (tgt % 256) : (m_pc + 1) % 256;
      end
    end else if (st) begin
      m_running = 1; m_done = 0;
      m_pc = addr % 256; m_sa = addr % 256; m_cycles = 0;
    end

    e.pc    = m_pc;
    e.sa    = m_sa;
    e.run   = int'(m_running);
    e.done  = int'(m_done);
    e.cnt16 = sat(m_cycles, 65535);
    e.cnt4  = sat(m_cycles, 15);
    exp_q.push_back(e);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, so one prediction per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc",        int'(pc_o),           e.pc);
      check("start_addr", int'(start_addr_o),  e.sa);
      check("running",   int'(running_o),      e.run);
      check("done",      int'(done_o),         e.done);
      check("count",     int'(cycle_count_o),  e.cnt16);
      check("pc_n",      int'(pc4_o),          e.pc);
      check("start_addr_n", int'(start_addr4_o), e.sa);
      check("running_n", int'(running4_o),     e.run);
      check("done_n",    int'(done4_o),        e.done);
      check("count_sat", int'(cycle_count4_o), e.cnt4);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; start_i = 0; start_addr_i = 0; branch_taken_i = 0;
    branch_target_i = 0; halt_i = 0; stall_i = 0;

    // Reset held with a competing start request.
    cycle(1, 1, 'h5E, 0, 0, 0, 0);
    cycle(1, 1, 'h5E, 0, 0, 0, 0);

    // Sequential fetch from 0x5E.
    cycle(0, 1, 'h5E, 0, 0, 0, 0);
    idle_cyc(3);
    cycle(0, 1, 'h33, 0, 0, 0, 0);          // start ignored in RUN
    cycle(0, 0, 0, 0, 0, 1, 0);             // halt -> DONE

    // Branch, stall and wrap from a restart at 0xAB.
    cycle(0, 1, 'hAB, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 'hFF, 0, 0);
    cycle(0, 0, 0, 1, 'h10, 0, 1);
    idle_cyc(1);

    // Halt beats stall and branch at pc 0x88; DONE then ignores everything.
    cycle(0, 0, 0, 1, 'h88, 0, 0);
    cycle(0, 0, 0, 1, 'h92, 1, 1);
    cycle(0, 0, 0, 1, 'h92, 1, 1);
    cycle(0, 0, 0, 1, 'h40, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Restart at 0x00, then a mid-run reset.
    cycle(0, 1, 'h00, 0, 0, 0, 0);
    idle_cyc(2);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle_cyc(1);

    // 20 non-halting RUN cycles: narrow counter pins at 0xF.
    cycle(0, 1, 'hF0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cycle(0, 0, 0, ($urandom_range(3) == 0), $urandom_range(255), 0,
            ($urandom_range(3) == 0));

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(63) == 0),
            ($urandom_range(7) == 0),
            $urandom_range(255),
            ($urandom_range(3) == 0),
            $urandom_range(255),
            ($urandom_range(31) == 0),
            ($urandom_range(3) == 0));
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and run-control stage directly upstream of the ALU. It holds the PC that addresses instruction memory and registers the program start address that the ALU uses for label resolution. It consumes the ALU's branch-taken flag and target address to redirect fetch. A small run/halt state machine starts a program, counts execution cycles and signals completion to the testbench.

Parameters:
PC_W, 8, width of PC, start address and branch target
CNT_W, 16, width of the execution cycle counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start_i  input  1  one-cycle request to begin execution at startAddr_i
startAddr_i  input  PC_W  program entry address, sampled on accepted start
branch_taken_i  input  1  ALU branch-taken flag for the instruction at pc_o
branch_target_i  input  PC_W  ALU-computed target (aluOut) for taken branch
halt_i  input  1  decoder flags the instruction at pc_o as program end
stall_i  input  1  hold the PC this cycle (multi-cycle memory op)
pc_o  output  PC_W  current instruction address
startAddr_o  output  PC_W  latched program start address, drives ALU startAddr_i
running_o  output  1  high while in RUN
done_o  output  1  high while in DONE
cycle_count_o  output  CNT_W  cycles spent in RUN for the current program

Behaviour:
- Single clock domain. All outputs are registered, with no combinational input-to-output paths.
- Reset: reset=1 at an edge forces state IDLE, pc_o=0, startAddr_o=0, running_o=0, done_o=0, cycle_count_o=0. Reset overrides every other input, including mid-RUN.
- States: IDLE, RUN, DONE. running_o=(state==RUN); done_o=(state==DONE).
- IDLE:
  - start_i=1 -> pc_o<=startAddr_i, startAddr_o<=startAddr_i, cycle_count_o<=0, go to RUN.
  - Otherwise hold all outputs.
- RUN, evaluated each edge with priority halt > stall > branch > sequential:
  - halt_i=1 -> go to DONE; pc_o holds.
  - stall_i=1 -> pc_o holds; branch_taken_i is ignored that cycle. The ALU re-presents it while stalled.
  - branch_taken_i=1 -> pc_o<=branch_target_i.
  - Otherwise pc_o<=pc_o+1, modulo 2^PC_W (0xFF -> 0x00, no flag).
  - cycle_count_o increments on every RUN edge, including stall cycles and the halt cycle. It saturates at all-ones and does not wrap.
  - start_i is ignored in RUN. startAddr_o is stable for the whole run.
- DONE:
  - pc_o, startAddr_o and cycle_count_o are frozen. halt_i, stall_i and branch inputs are ignored.
  - start_i=1 -> restart exactly as from IDLE: load pc_o and startAddr_o, clear count, go to RUN, done_o drops next cycle.
- Latency: redirect is one cycle. branch_taken_i sampled at edge N gives pc_o=target after edge N, with no delay slot.
- Width rule: PC arithmetic is unsigned PC_W bits. branch_target_i is used verbatim, with no offset or sign extension.
- Simultaneous start_i and reset: reset wins, state stays IDLE.

Test Plan:
- Reset: hold reset 2 cycles with start_i=1 and startAddr_i=0x5E -> pc_o=0x00, startAddr_o=0x00, running_o=0, done_o=0, cycle_count_o=0.
- Sequential fetch: start_i pulse with startAddr_i=0x5E, then 3 idle cycles -> pc_o=0x5E, 0x5F, 0x60, 0x61; startAddr_o=0x5E; running_o=1; cycle_count_o=3.
- Branch, stall and wrap:
  - Start at 0xAB; assert branch_taken_i with target 0xFF -> pc_o=0xFF.
  - Next cycle assert stall_i with branch_taken_i=1, target 0x10 -> pc_o stays 0xFF.
  - Next cycle, no branch -> pc_o=0x00.
- Halt priority: in RUN at pc 0x88, assert halt_i, branch_taken_i (target 0x92) and stall_i together -> state DONE, pc_o=0x88, done_o=1, running_o=0, count includes the halt cycle. Later input toggles leave everything frozen.
- Restart and mid-run reset:
  - From DONE, start_i with startAddr_i=0x00 -> pc_o=0x00, count=0, running_o=1.
  - Two cycles later assert reset -> all outputs return to reset values on the next edge.
- Counter saturation: with CNT_W=4, run 20 non-halting cycles -> cycle_count_o stops at 0xF.
